// File: rtl/control_pkg.sv
// Shared types for the multi-cycle MIPS controller: FSM states, opcodes and
// the instruction classes produced by the opcode decoder.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LW   = 3'd1,
        CLS_SW   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_ADDI = 3'd4,
        CLS_ILL  = 3'd5
    } cls_e;

endpackage

// File: rtl/control_multiciclo_decod_opcode.sv
// decod_opcode: combinational opcode-to-class mapping with illegal detect.
module decod_opcode
    import control_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [2:0] cls_o,
    output logic       illegal_o
);

    // Map the latched opcode to its execution class; unknown opcodes are illegal.
    always_comb begin
        cls_o     = CLS_ILL;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_R:    cls_o = CLS_R;
            OP_LW:   cls_o = CLS_LW;
            OP_SW:   cls_o = CLS_SW;
            OP_BEQ:  cls_o = CLS_BEQ;
            OP_ADDI: cls_o = CLS_ADDI;
            default: begin
                cls_o     = CLS_ILL;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle sequencer FETCH/DECODE/EXEC/MEM/WB with retired counter and
// sticky illegal flag. Define CTRL_MEM_WAIT_EN to make MEM wait for mem_ready.
module control_multiciclo
    import control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instruccion,
    input  logic             mem_ready,
    output logic             instr_ready,
    output logic             ir_we,
    output logic             sel,
    output logic             sel2,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             pc_we,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [5:0]       opcode_q;
    logic [2:0]       cls_raw_s;
    cls_e             cls_s;
    logic             ill_s;
    logic             mem_done_s;
    logic             retire_s;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             instr_ready_q, instr_ready_d;
    logic             busy_q, busy_d;
    logic             sel_q, sel_d;
    logic             sel2_q, sel2_d;
    logic             reg_we_q, reg_we_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             unused_s;

    decod_opcode u_decod (
        .opcode_i  (opcode_q),
        .cls_o     (cls_raw_s),
        .illegal_o (ill_s)
    );

    assign cls_s = cls_e'(cls_raw_s);

`ifdef CTRL_MEM_WAIT_EN
    assign mem_done_s = mem_ready;
    assign unused_s   = ^instruccion[25:0];
`else
    assign mem_done_s = 1'b1;
    assign unused_s   = ^{instruccion[25:0], mem_ready};
`endif

    // instr_ready is registered, so nothing is accepted while reset is held.
    assign ir_we = instr_ready_q & instr_valid;

    // Next-state logic plus the step-completion strobes seen by the PC.
    always_comb begin
        state_d  = state_q;
        pc_we    = 1'b0;
        retire_s = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (ir_we) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (ill_s) begin
                    state_d = ST_FETCH;
                    pc_we   = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_BEQ: begin
                        state_d  = ST_FETCH;
                        pc_we    = 1'b1;
                        retire_s = 1'b1;
                    end
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (!mem_done_s) begin
                    state_d = ST_MEM;
                end else if (cls_s == CLS_LW) begin
                    state_d = ST_WB;
                end else begin
                    state_d  = ST_FETCH;
                    pc_we    = 1'b1;
                    retire_s = 1'b1;
                end
            end
            ST_WB: begin
                state_d  = ST_FETCH;
                pc_we    = 1'b1;
                retire_s = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        instr_ready_d = (state_d == ST_FETCH);
        busy_d        = (state_d != ST_FETCH);
        sel2_d        = (state_d == ST_EXEC) && (cls_s == CLS_BEQ);
        sel_d         = (state_d == ST_WB) && (cls_s == CLS_R);
        reg_we_d      = (state_d == ST_WB);
        mem_rd_d      = (state_d == ST_MEM) && (cls_s == CLS_LW);
        mem_wr_d      = (state_d == ST_MEM) && (cls_s == CLS_SW);
    end

    // State, latched opcode, counter, sticky flag and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            opcode_q      <= 6'd0;
            retired_q     <= {CNT_W{1'b0}};
            illegal_q     <= 1'b0;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            sel_q         <= 1'b0;
            sel2_q        <= 1'b0;
            reg_we_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_we) begin
                opcode_q <= instruccion[31:26];
            end else begin
                opcode_q <= opcode_q;
            end
            if (retire_s) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_q <= retired_q;
            end
            if ((state_q == ST_DECODE) && ill_s) begin
                illegal_q <= 1'b1;
            end else begin
                illegal_q <= illegal_q;
            end
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            sel_q         <= sel_d;
            sel2_q        <= sel2_d;
            reg_we_q      <= reg_we_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign sel         = sel_q;
    assign sel2        = sel2_q;
    assign reg_we      = reg_we_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo; honours CTRL_MEM_WAIT_EN when defined.
module tb_control_multiciclo;
    import control_pkg::*;

`ifdef CTRL_MEM_WAIT_EN
    localparam int MEM_CYC = 4;
`else
    localparam int MEM_CYC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instruccion;
    logic        mem_ready;
    logic        instr_ready, ir_we, sel, sel2, reg_we, mem_rd, mem_wr, pc_we, busy, illegal;
    logic [31:0] retired;

    int n_total = 0;
    int n_bad   = 0;

    control_multiciclo #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instruccion (instruccion),
        .mem_ready   (mem_ready),
        .instr_ready (instr_ready),
        .ir_we       (ir_we),
        .sel         (sel),
        .sel2        (sel2),
        .reg_we      (reg_we),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .pc_we       (pc_we),
        .busy        (busy),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a word, check the accept strobe and leave the bench in cycle 1.
    task automatic issue(input logic [31:0] word);
        int guard = 0;
        while (!instr_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instruccion = word;
        #1;
        chk("ir_we_c0", {31'd0, ir_we}, 32'd1);
        tick();
        instr_valid = 1'b0;
        instruccion = 32'h0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instruccion = 32'h012A4020;
        mem_ready   = 1'b0;

        // Reset held two cycles with a valid word pending.
        tick();
        tick();
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_irwe", {31'd0, ir_we}, 32'd0);
        chk("rst_outs", {25'd0, sel, sel2, reg_we, mem_rd, mem_wr, busy, illegal}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        tick();
        chk("rel_fetch", {30'd0, instr_ready, busy}, 32'd2);

        // R-type: reg_we and sel only in cycle 3.
        issue(32'h012A4020);
        chk("r_c1", {29'd0, busy, reg_we, sel}, 32'd4);
        tick();
        chk("r_c2", {30'd0, reg_we, sel}, 32'd0);
        tick();
        chk("r_c3", {29'd0, reg_we, sel, pc_we}, 32'd7);
        tick();
        chk("r_c4", {30'd0, instr_ready, reg_we}, 32'd2);
        chk("r_retired", retired, 32'd1);

        // LW: mem_rd for MEM_CYC cycles, then WB with sel=0.
        issue(32'h8D090004);
        tick();
        chk("lw_exec", {30'd0, mem_rd, sel2}, 32'd0);
        tick();
        for (int k = 0; k < MEM_CYC; k++) begin
`ifdef CTRL_MEM_WAIT_EN
            mem_ready = (k == MEM_CYC - 1);
`endif
            #1;
            chk("lw_memrd", {30'd0, mem_rd, reg_we}, 32'd2);
            tick();
        end
        mem_ready = 1'b0;
        chk("lw_wb", {29'd0, reg_we, sel, mem_rd}, 32'd4);
        tick();
        chk("lw_done", {31'd0, instr_ready}, 32'd1);
        chk("lw_retired", retired, 32'd2);

        // BEQ: sel2 in EXEC, no reg_we, back in FETCH after 3 cycles.
        issue(32'h1109FFFF);
        chk("beq_c1", {30'd0, sel2, reg_we}, 32'd0);
        tick();
        chk("beq_exec", {29'd0, sel2, reg_we, pc_we}, 32'd5);
        tick();
        chk("beq_c3", {29'd0, instr_ready, sel2, reg_we}, 32'd4);
        chk("beq_retired", retired, 32'd3);

        // Illegal opcode followed by ADDI: flag sticky, counter skips the illegal word.
        issue(32'hFC000000);
        chk("ill_c1", {30'd0, pc_we, illegal}, 32'd2);
        tick();
        chk("ill_c2", {30'd0, instr_ready, illegal}, 32'd3);
        chk("ill_retired", retired, 32'd3);
        issue(32'h21080001);
        tick();
        tick();
        chk("addi_wb", {29'd0, reg_we, sel, illegal}, 32'd5);
        tick();
        chk("addi_done", {30'd0, instr_ready, illegal}, 32'd3);
        chk("addi_retired", retired, 32'd4);

        // Reset in MEM of SW aborts it; next instruction runs normally.
        issue(32'hAD090004);
        tick();
        tick();
        chk("sw_mem", {31'd0, mem_wr}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("sw_rst_outs", {28'd0, mem_wr, mem_rd, reg_we, busy}, 32'd0);
        chk("sw_rst_retired", retired, 32'd0);
        rst_n = 1'b1;
        tick();
        issue(32'h012A4020);
        tick();
        tick();
        chk("post_wb", {30'd0, reg_we, sel}, 32'd3);
        tick();
        chk("post_retired", retired, 32'd1);
        chk("post_illegal", {31'd0, illegal}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
